// File: rtl/serial_adder_decod.sv
// Sequential WIDTH-bit adder: BITS_PER_CYCLE decoder full-adder cells per clock, registered carry chain.
// Optional macro SERIAL_ADD_SUB_EN adds a subtract mode (a + ~b + 1) selected by sub at capture.
module serial_adder_decod #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    r_state;
   logic [WIDTH-1:0]          r_a;
   logic [WIDTH-1:0]          r_b;
   logic                      r_carry;
   logic [WIDTH-1:0]          r_sh;
   logic [CNT_W-1:0]          r_cnt;

   logic [WIDTH-1:0]          w_b_eff;
   logic                      w_cin_eff;
   logic [BITS_PER_CYCLE:0]   w_c;
   logic [BITS_PER_CYCLE-1:0] w_s;
   logic [WIDTH-1:0]          w_sh_next;

   // Full adder as 3-to-8 minterm decode; returns {carry, sum}
   function automatic logic [1:0] dec_fa(input logic ia, input logic ib, input logic ic);
      logic [7:0] m;
      m = 8'b1 << {ia, ib, ic};
      return {m[3] | m[5] | m[6] | m[7], m[1] | m[2] | m[4] | m[7]};
   endfunction

`ifdef SERIAL_ADD_SUB_EN
   assign w_b_eff   = sub ? ~b : b;
   assign w_cin_eff = sub | cin;
`else
   logic w_unused_sub;
   assign w_unused_sub = sub;
   assign w_b_eff      = b;
   assign w_cin_eff    = cin;
`endif

   always_comb begin
      w_c    = '0;
      w_s    = '0;
      w_c[0] = r_carry;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         {w_c[i+1], w_s[i]} = dec_fa(r_a[i], r_b[i], w_c[i]);
      end
      // Result bits enter at the top so the LSB slice ends up at bit 0 after N shifts
      w_sh_next = r_sh >> BITS_PER_CYCLE;
      w_sh_next[WIDTH-1 -: BITS_PER_CYCLE] = w_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_sh     <= '0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= w_b_eff;
                  r_carry <= w_cin_eff;
                  r_sh    <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> BITS_PER_CYCLE;
               r_b     <= r_b >> BITS_PER_CYCLE;
               r_carry <= w_c[BITS_PER_CYCLE];
               r_sh    <= w_sh_next;
               r_cnt   <= r_cnt + 1'b1;
               // Last slice holds the MSB cell: its carry-in is w_c[BITS_PER_CYCLE-1]
               if (r_cnt == LAST) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  sum      <= w_sh_next;
                  cout     <= w_c[BITS_PER_CYCLE];
                  overflow <= w_c[BITS_PER_CYCLE] ^ w_c[BITS_PER_CYCLE-1];
                  r_state  <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
